// File: rtl/cpu_phase_gen.sv
// Programmable divider producing NUM_PHASES phase-shifted square waves and
// per-period enable pulses, with a lock indicator after a settling window.
module cpu_phase_gen #(
    parameter int NUM_PHASES   = 3,
    parameter int DIV_WIDTH    = 8,
    parameter int LOCK_PERIODS = 4
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic [DIV_WIDTH-1:0]             cfg_div,
    input  logic [NUM_PHASES*DIV_WIDTH-1:0]  cfg_phase,
    output logic [NUM_PHASES-1:0]            outclk,
    output logic [NUM_PHASES-1:0]            outclk_en,
    output logic                             locked
);

    localparam int LW = $clog2(LOCK_PERIODS + 1);
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

    typedef enum logic [1:0] {
        S_RESET,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    state_t                          r_state;
    state_t                          w_next_state;
    logic [DIV_WIDTH-1:0]            r_cfg_div_raw;
    logic [NUM_PHASES*DIV_WIDTH-1:0] r_cfg_phase_raw;
    logic [DIV_WIDTH-1:0]            r_div;
    logic [DIV_WIDTH-1:0]            r_phase [NUM_PHASES];
    logic [DIV_WIDTH-1:0]            r_cnt;
    logic [LW-1:0]                   r_lock_cnt;

    logic [DIV_WIDTH-1:0]            w_ld_div;
    logic [DIV_WIDTH-1:0]            w_ld_max;
    logic [DIV_WIDTH-1:0]            w_ld_phase [NUM_PHASES];
    logic [DIV_WIDTH:0]              w_diff [NUM_PHASES];
    logic [DIV_WIDTH:0]              w_half;
    logic [NUM_PHASES-1:0]           w_hit;
    logic [NUM_PHASES-1:0]           w_high;
    logic                            w_run;
    logic                            w_cfg_change;
    logic                            w_load;
    logic                            w_wrap;
    logic                            w_lock_done;
    logic [NUM_PHASES-1:0]           w_outclk_d;
    logic [NUM_PHASES-1:0]           w_outclk_en_d;
    logic                            w_locked_d;

    assign w_ld_div     = (cfg_div < TWO) ? TWO : cfg_div;
    assign w_ld_max     = w_ld_div - ONE;
    assign w_half       = {1'b0, r_div >> 1};
    assign w_run        = (r_state != S_RESET);
    assign w_cfg_change = w_run && ((cfg_div != r_cfg_div_raw) ||
                                    (cfg_phase != r_cfg_phase_raw));
    assign w_load       = !rst && (!w_run || w_cfg_change);
    assign w_wrap       = (r_cnt == r_div - ONE);
    assign w_lock_done  = (r_state == S_ACQUIRE) && w_wrap &&
                          (r_lock_cnt == LW'(LOCK_PERIODS - 1));

    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_ch
        logic [DIV_WIDTH-1:0] w_req;
        assign w_req         = cfg_phase[k*DIV_WIDTH +: DIV_WIDTH];
        assign w_ld_phase[k] = (w_req > w_ld_max) ? w_ld_max : w_req;
        assign w_hit[k]      = (r_cnt == r_phase[k]);
        // Distance from the channel's phase point, modulo the period.
        assign w_diff[k]     = (r_cnt >= r_phase[k]) ?
                               {1'b0, r_cnt - r_phase[k]} :
                               {1'b0, r_cnt} + {1'b0, r_div} - {1'b0, r_phase[k]};
        assign w_high[k]     = (w_diff[k] < w_half);
    end

    always_ff @(posedge refclk) begin
        if (rst) r_state <= S_RESET;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (rst) begin
            w_next_state = S_RESET;
        end else begin
            case (r_state)
                S_RESET:   w_next_state = S_ACQUIRE;
                S_ACQUIRE: begin
                    if (w_cfg_change)     w_next_state = S_ACQUIRE;
                    else if (w_lock_done) w_next_state = S_LOCKED;
                end
                S_LOCKED:  if (w_cfg_change) w_next_state = S_ACQUIRE;
                default:   w_next_state = S_RESET;
            endcase
        end
    end

    always_comb begin
        w_outclk_d    = '0;
        w_outclk_en_d = '0;
        w_locked_d    = 1'b0;
        if (!rst && w_run && !w_cfg_change) begin
            w_outclk_d    = w_high;
            w_outclk_en_d = w_hit;
            w_locked_d    = (r_state == S_LOCKED) || w_lock_done;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_lock_cnt      <= '0;
            r_div           <= TWO;
            r_cfg_div_raw   <= '0;
            r_cfg_phase_raw <= '0;
            for (int k = 0; k < NUM_PHASES; k++) r_phase[k] <= '0;
        end else if (w_load) begin
            r_cnt           <= '0;
            r_lock_cnt      <= '0;
            r_div           <= w_ld_div;
            r_cfg_div_raw   <= cfg_div;
            r_cfg_phase_raw <= cfg_phase;
            for (int k = 0; k < NUM_PHASES; k++) r_phase[k] <= w_ld_phase[k];
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + ONE;
            if (r_state == S_ACQUIRE && w_wrap &&
                r_lock_cnt < LW'(LOCK_PERIODS))
                r_lock_cnt <= r_lock_cnt + LW'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            outclk    <= '0;
            outclk_en <= '0;
            locked    <= 1'b0;
        end else begin
            outclk    <= w_outclk_d;
            outclk_en <= w_outclk_en_d;
            locked    <= w_locked_d;
        end
    end

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Scoreboard bench for cpu_phase_gen: driver pushes model predictions,
// monitor pops one per clock and compares against the DUT outputs.
module tb_cpu_phase_gen;

    localparam int NP = 3;
    localparam int DW = 8;
    localparam int LP = 4;

    typedef struct packed {
        logic [NP-1:0] clk;
        logic [NP-1:0] en;
        logic          lk;
    } exp_t;

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    cfg_div = '0;
    logic [NP*DW-1:0] cfg_phase = '0;
    logic [NP-1:0]    outclk;
    logic [NP-1:0]    outclk_en;
    logic             locked;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    // Reference model: time since load, period and clamped phases.
    bit              m_run = 1'b0;
    logic [DW-1:0]    m_rd;
    logic [NP*DW-1:0] m_rp;
    int              m_D;
    int              m_P[NP];
    int              m_n;

    cpu_phase_gen #(
        .NUM_PHASES(NP),
        .DIV_WIDTH(DW),
        .LOCK_PERIODS(LP)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .cfg_div(cfg_div),
        .cfg_phase(cfg_phase),
        .outclk(outclk),
        .outclk_en(outclk_en),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    task automatic step(input logic r, input logic [DW-1:0] d,
                        input logic [NP*DW-1:0] ph);
        exp_t e;
        int   c;
        int   p;
        @(negedge refclk);
        rst       = r;
        cfg_div   = d;
        cfg_phase = ph;
        e = '0;
        if (r) begin
            m_run = 1'b0;
        end else if (!m_run || d != m_rd || ph != m_rp) begin
            m_run = 1'b1;
            m_rd  = d;
            m_rp  = ph;
            m_D   = (int'(d) < 2) ? 2 : int'(d);
            for (int k = 0; k < NP; k++) begin
                p = int'(ph[k*DW +: DW]);
                m_P[k] = (p > m_D - 1) ? m_D - 1 : p;
            end
            m_n = 0;
        end else begin
            c = m_n % m_D;
            for (int k = 0; k < NP; k++) begin
                e.en[k]  = (c == m_P[k]);
                e.clk[k] = (((c - m_P[k] + m_D) % m_D) < (m_D / 2));
            end
            e.lk = ((m_n + 1) / m_D) >= LP;
            m_n++;
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [DW-1:0] d, input logic [NP*DW-1:0] ph,
                       input int n);
        repeat (n) step(1'b0, d, ph);
    endtask

    always @(posedge refclk) begin
        exp_t e;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({outclk, outclk_en, locked} !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got clk=%b en=%b lk=%b exp clk=%b en=%b lk=%b",
                         cyc, outclk, outclk_en, locked, e.clk, e.en, e.lk);
            end
        end
    end

    initial begin
        logic [DW-1:0]    d;
        logic [NP*DW-1:0] ph;
        int               len;
        repeat (3) step(1'b1, 8'd6, {8'd4, 8'd2, 8'd0});
        run(8'd6, {8'd4, 8'd2, 8'd0}, 40);
        run(8'd6, {8'd1, 8'd3, 8'd5}, 40);
        run(8'd0, {8'd1, 8'd0, 8'd0}, 12);
        run(8'd1, {8'd1, 8'd0, 8'd0}, 12);
        run(8'd5, {8'd9, 8'd9, 8'd9}, 40);
        // Change lands exactly on the wrap that would complete lock.
        run(8'd6, {8'd0, 8'd1, 8'd2}, 4 * 6);
        run(8'd6, {8'd2, 8'd1, 8'd0}, 40);
        step(1'b1, 8'd6, {8'd2, 8'd1, 8'd0});
        run(8'd6, {8'd2, 8'd1, 8'd0}, 40);
        repeat (40) begin
            d = DW'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0)
                ph = NP*DW'($urandom);
            else
                ph = {DW'($urandom_range(0, 13)), DW'($urandom_range(0, 13)),
                      DW'($urandom_range(0, 13))};
            len = $urandom_range(1, 6 * (int'(d) + 2) + 12);
            for (int i = 0; i < len; i++)
                step(($urandom_range(0, 59) == 0), d, ph);
        end
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge refclk);
        @(negedge refclk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_phase_gen.md
CPU_PHASE_GEN -- requirements
Module: cpu_phase_gen

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 3, the number of output phase channels (1..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 8, the width of the divider and phase fields.
REQ-003 SHALL have parameter LOCK_PERIODS, default 4, the number of full output periods from config load to locked.
REQ-004 SHALL have port refclk  input  1  the sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cfg_div  input  DIV_WIDTH  the requested output period in refclk cycles.
REQ-007 SHALL have port cfg_phase  input  NUM_PHASES*DIV_WIDTH  the requested phase offset per channel in refclk cycles; channel k is bits [k*DIV_WIDTH +: DIV_WIDTH].
REQ-008 SHALL have port outclk  output  NUM_PHASES  the phase-shifted square-wave level per channel.
REQ-009 SHALL have port outclk_en  output  NUM_PHASES  a one-refclk-cycle enable pulse per channel, once per period.
REQ-010 SHALL have port locked  output  1  high while the active configuration is stable and settled.

Function
REQ-011 SHALL implement states RESET, ACQUIRE and LOCKED.
REQ-012 SHALL move from RESET to ACQUIRE on the first cycle with rst low, loading the active config from cfg_div/cfg_phase.
REQ-013 SHALL clamp the effective divider D to max(cfg_div, 2) at load.
REQ-014 SHALL clamp each effective phase P_k to min(cfg_phase_k, D-1) at load.
REQ-015 SHALL keep a period counter cnt that counts 0..D-1 and then wraps to 0; a wrap is the cycle in which cnt==D-1.
REQ-016 SHALL set cnt to 0 and the lock counter to 0 whenever a config is loaded.
REQ-017 SHALL register outclk_en[k] high for exactly the one cycle after a cycle with cnt==P_k, and low otherwise.
REQ-018 SHALL register outclk[k] high in the cycle after a cycle in which ((cnt - P_k) mod D) < floor(D/2), and low otherwise; odd D gives a low phase one cycle longer than the high phase.
REQ-019 SHALL drive outclk and outclk_en during both ACQUIRE and LOCKED.
REQ-020 SHALL increment the lock counter on each wrap while in ACQUIRE, and move to LOCKED with locked=1 on the wrap that brings it to LOCK_PERIODS.
REQ-021 SHALL detect a config change as the raw cfg_div or cfg_phase differing from the raw values captured at the last load.
REQ-022 SHALL handle a config change in ACQUIRE or LOCKED by re-loading on the next cycle: locked=0, state ACQUIRE, counters cleared, and outclk/outclk_en forced to 0 for that cycle.
REQ-023 SHALL let a config change take precedence over a simultaneous wrap or lock-counter completion, so locked is not asserted on that wrap.
REQ-024 SHALL keep the lock counter saturated at LOCK_PERIODS while in LOCKED.

Reset
REQ-025 SHALL put the block in RESET while rst is high, with cnt=0, lock counter=0, outclk=0, outclk_en=0 and locked=0.
REQ-026 SHALL have rst asserted mid-operation take effect on the next edge, overriding all other events; the config is re-loaded on release.

Verification
REQ-027 SHALL be verified by: NUM_PHASES=3, cfg_div=6, phases 0/2/4 -> outclk_en pulses 2 cycles apart, each channel has a period of 6 and 3 cycles high; locked rises at the end of the 4th period after release.
REQ-028 SHALL be verified by: cfg_div=0 and then cfg_div=1 -> D=2, outclk toggles every cycle, outclk_en pulses every 2 cycles.
REQ-029 SHALL be verified by: cfg_div=5, phase 9 -> P clamped to 4; outclk has 2 cycles high and 3 low; pulse once every 5 cycles.
REQ-030 SHALL be verified by: change cfg_phase while locked -> locked=0 and outputs=0 on the next cycle; relock after 4 periods with the new phase.
REQ-031 SHALL be verified by: change the config on the exact wrap that would complete lock -> locked stays 0 and a full 4-period acquire restarts.
REQ-032 SHALL be verified by: rst pulsed for 1 cycle mid-period while locked -> all outputs 0 on the next cycle, then a normal acquire from cnt=0.
